spi_target: RTL

- SPI mode-0 target (slave) that answers an external SPI initiator. It is the far end of the SoC SPI master's sclk/mosi/miso/ssn protocol.
- Lets a second LnL SoC, or a bench, talk to this chip as a peripheral.
- The CPU side uses the same load/unload strobe style as the on-chip master.
- The SPI pins are oversampled in the clk domain; there is no second clock domain.

---
 rtl/spi_target_pkg.sv | 18 +
 rtl/spi_target_if.sv | 25 ++
 rtl/spi_target_sync.sv | 22 ++
 rtl/spi_target.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/spi_target_pkg.sv
// Shared types and constants for the SPI mode-0 target.
package spi_target_pkg;

    localparam int DATA_W_DEF = 8;

    // Bit-counter width; a 1-bit frame still needs a 1-bit counter.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(DATA_W_DEF);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/spi_target_if.sv
// CPU-side load/unload bus of the SPI target.
interface spi_target_if
    import spi_target_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              load;
    logic              unload;
    logic [DATA_W-1:0] datain;
    logic [DATA_W-1:0] dataout;
    logic              rx_valid;
    logic              tx_empty;
    logic              overrun;
    logic              busy;

    modport master (
        output load, unload, datain,
        input  dataout, rx_valid, tx_empty, overrun, busy
    );

    modport slave (
        input  load, unload, datain,
        output dataout, rx_valid, tx_empty, overrun, busy
    );
endinterface

// File: rtl/spi_target_sync.sv
// N-stage flop synchronizer with a selectable reset value.
module spi_target_sync #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= {STAGES{RST_VAL}};
        end else begin
            sync_reg <= {sync_reg[STAGES-2:0], d};
        end
    end

    assign q = sync_reg[STAGES-1];
endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target: oversampled sclk/mosi/ssn, single TX and RX byte buffers
// towards the CPU with load/unload strobes.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_in,
    input  logic mosi_in,
    input  logic ssn_in,
    output logic miso_out,
    output logic miso_oe,
    spi_target_if.slave cpu
);
    localparam int CW = cnt_width(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    logic sclk_s, mosi_s, ssn_s;
    logic sclk_d_reg, ssn_d_reg;
    logic sclk_rise, sclk_fall, ssn_fall, ssn_rise;

    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [DATA_W-1:0] shift_reg, shift_next;
    logic              miso_reg, miso_next;
    logic [DATA_W-1:0] tx_buf_reg, tx_buf_next;
    logic              tx_empty_reg, tx_empty_next;
    logic [DATA_W-1:0] rx_buf_reg, rx_buf_next;
    logic              rx_valid_reg, rx_valid_next;
    logic              overrun_reg, overrun_next;
    logic              tx_take;
    logic [DATA_W-1:0] tx_word;
    logic [DATA_W-1:0] byte_in;

    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d(sclk_in), .q(sclk_s)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst_n(rst_n), .d(mosi_in), .q(mosi_s)
    );
    spi_target_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ssn (
        .clk(clk), .rst_n(rst_n), .d(ssn_in), .q(ssn_s)
    );

    assign sclk_rise =  sclk_s & ~sclk_d_reg;
    assign sclk_fall = ~sclk_s &  sclk_d_reg;
    assign ssn_fall  = ~ssn_s  &  ssn_d_reg;
    assign ssn_rise  =  ssn_s  & ~ssn_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            shift_reg    <= '0;
            miso_reg     <= 1'b0;
            tx_buf_reg   <= '0;
            tx_empty_reg <= 1'b1;
            rx_buf_reg   <= '0;
            rx_valid_reg <= 1'b0;
            overrun_reg  <= 1'b0;
            sclk_d_reg   <= 1'b0;
            ssn_d_reg    <= 1'b1;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            shift_reg    <= shift_next;
            miso_reg     <= miso_next;
            tx_buf_reg   <= tx_buf_next;
            tx_empty_reg <= tx_empty_next;
            rx_buf_reg   <= rx_buf_next;
            rx_valid_reg <= rx_valid_next;
            overrun_reg  <= overrun_next;
            sclk_d_reg   <= sclk_s;
            ssn_d_reg    <= ssn_s;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        shift_next    = shift_reg;
        miso_next     = miso_reg;
        tx_buf_next   = tx_buf_reg;
        tx_empty_next = tx_empty_reg;
        rx_buf_next   = rx_buf_reg;
        rx_valid_next = rx_valid_reg;
        overrun_next  = overrun_reg;
        tx_take       = 1'b0;
        tx_word       = tx_empty_reg ? '0 : tx_buf_reg;
        byte_in       = {shift_reg[DATA_W-2:0], mosi_s};

        if (cpu.unload) begin
            rx_valid_next = 1'b0;
            overrun_next  = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (ssn_fall) begin
                    state_next = ACTIVE;
                    shift_next = tx_word;
                    miso_next  = tx_word[DATA_W-1];
                    tx_take    = 1'b1;
                end
            end
            ACTIVE: begin
                // Deselect wins over any sclk edge seen in the same cycle.
                if (ssn_rise) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    miso_next  = 1'b0;
                end else if (sclk_rise) begin
                    shift_next = byte_in;
                    if (cnt_reg == LAST_BIT) begin
                        cnt_next = '0;
                        if (!rx_valid_reg || cpu.unload) begin
                            rx_buf_next   = byte_in;
                            rx_valid_next = 1'b1;
                        end else begin
                            overrun_next = 1'b1;
                        end
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end else if (sclk_fall) begin
                    // Byte boundary: next TX byte follows without a gap.
                    if (cnt_reg == '0) begin
                        shift_next = tx_word;
                        miso_next  = tx_word[DATA_W-1];
                        tx_take    = 1'b1;
                    end else begin
                        miso_next = shift_reg[DATA_W-1];
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // A same-cycle load leaves a new byte pending after the transfer.
        if (cpu.load) begin
            tx_buf_next   = cpu.datain;
            tx_empty_next = 1'b0;
        end else if (tx_take) begin
            tx_empty_next = 1'b1;
        end
    end

    assign miso_out     = miso_reg;
    assign miso_oe      = (state_reg == ACTIVE);
    assign cpu.busy     = (state_reg == ACTIVE);
    assign cpu.dataout  = rx_buf_reg;
    assign cpu.rx_valid = rx_valid_reg;
    assign cpu.tx_empty = tx_empty_reg;
    assign cpu.overrun  = overrun_reg;
endmodule
